// File: rtl/ram_wr.sv
// rtl/ram_wr.sv - two-stage write pipeline into eight word registers and one output port
//
// Purpose:
//   Accepts one write per cycle. Stage S1 registers the request. Stage S2
//   commits it one edge later into RAM_0..RAM_7 (addresses 8'h00..8'h07) or
//   into IO64_OUT (address 8'h40). Any other address is unmapped: nothing is
//   stored and the sticky WR_ERR flag is set.
//
// Configuration:
//   RAM_WR_COUNT_EN - when defined, WR_CNT counts mapped commits modulo 256.
//                     When undefined, WR_CNT is constant 8'h00.
//
// Ports:
//   CLK_WR          in   clock, rising edge
//   RESET_N         in   asynchronous active-low reset
//   RAM_WEN         in   write request
//   RAM_AD_IN[7:0]  in   write address
//   RAM_IN[15:0]    in   write data
//   ERR_CLR         in   clears WR_ERR; a same-edge unmapped commit still sets it
//   RAM_0..RAM_7    out  registered word storage
//   IO64_OUT[15:0]  out  registered output port at 8'h40
//   IO64_STB        out  one-cycle pulse after each IO64_OUT commit
//   WR_ERR          out  sticky unmapped-write flag
//   WR_CNT[7:0]     out  committed (mapped) write count
module ram_wr (
  input  logic        CLK_WR,
  input  logic        RESET_N,
  input  logic        RAM_WEN,
  input  logic [7:0]  RAM_AD_IN,
  input  logic [15:0] RAM_IN,
  input  logic        ERR_CLR,
  output logic [15:0] RAM_0,
  output logic [15:0] RAM_1,
  output logic [15:0] RAM_2,
  output logic [15:0] RAM_3,
  output logic [15:0] RAM_4,
  output logic [15:0] RAM_5,
  output logic [15:0] RAM_6,
  output logic [15:0] RAM_7,
  output logic [15:0] IO64_OUT,
  output logic        IO64_STB,
  output logic        WR_ERR,
  output logic [7:0]  WR_CNT
);

  localparam logic [7:0] IO64_ADDR = 8'h40;

  // Stage S1
  logic        s1_vld_q, s1_vld_d;
  logic [7:0]  s1_ad_q, s1_ad_d;
  logic [15:0] s1_data_q, s1_data_d;

  // Stage S2 (architectural state)
  logic [7:0][15:0] ram_q, ram_d;
  logic [15:0]      io64_q, io64_d;
  logic             stb_q, stb_d;
  logic             err_q, err_d;

  logic             commit_ram;
  logic             commit_io;

  always_comb begin
    commit_ram = s1_vld_q && (s1_ad_q[7:3] == 5'b00000);
    commit_io  = s1_vld_q && (s1_ad_q == IO64_ADDR);
  end

  always_comb begin
    s1_vld_d  = RAM_WEN;
    // Address/data only load on a request so idle cycles do not toggle them.
    s1_ad_d   = RAM_WEN ? RAM_AD_IN : s1_ad_q;
    s1_data_d = RAM_WEN ? RAM_IN    : s1_data_q;

    ram_d  = ram_q;
    io64_d = io64_q;
    stb_d  = 1'b0;
    err_d  = err_q & ~ERR_CLR;

    if (commit_ram) begin
      ram_d[s1_ad_q[2:0]] = s1_data_q;
    end else if (commit_io) begin
      io64_d = s1_data_q;
      stb_d  = 1'b1;
    end else if (s1_vld_q) begin
      // Unmapped commit: set has priority over a same-edge clear.
      err_d = 1'b1;
    end
  end

  always_ff @(posedge CLK_WR or negedge RESET_N) begin
    if (!RESET_N) begin
      s1_vld_q  <= 1'b0;
      s1_ad_q   <= 8'h00;
      s1_data_q <= 16'h0000;
      ram_q     <= '0;
      io64_q    <= 16'h0000;
      stb_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_ad_q   <= s1_ad_d;
      s1_data_q <= s1_data_d;
      ram_q     <= ram_d;
      io64_q    <= io64_d;
      stb_q     <= stb_d;
      err_q     <= err_d;
    end
  end

`ifdef RAM_WR_COUNT_EN
  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (commit_ram || commit_io) begin
      cnt_d = cnt_q + 8'h01;
    end
  end

  always_ff @(posedge CLK_WR or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt_q <= 8'h00;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign WR_CNT = cnt_q;
`else
  assign WR_CNT = 8'h00;
`endif

  assign RAM_0    = ram_q[0];
  assign RAM_1    = ram_q[1];
  assign RAM_2    = ram_q[2];
  assign RAM_3    = ram_q[3];
  assign RAM_4    = ram_q[4];
  assign RAM_5    = ram_q[5];
  assign RAM_6    = ram_q[6];
  assign RAM_7    = ram_q[7];
  assign IO64_OUT = io64_q;
  assign IO64_STB = stb_q;
  assign WR_ERR   = err_q;

endmodule

// File: tb/tb_ram_wr.sv
// tb/tb_ram_wr.sv - scoreboard testbench for ram_wr
module tb_ram_wr;

  logic        CLK_WR = 1'b0;
  logic        RESET_N;
  logic        RAM_WEN;
  logic [7:0]  RAM_AD_IN;
  logic [15:0] RAM_IN;
  logic        ERR_CLR;
  logic [15:0] RAM_0, RAM_1, RAM_2, RAM_3, RAM_4, RAM_5, RAM_6, RAM_7;
  logic [15:0] IO64_OUT;
  logic        IO64_STB;
  logic        WR_ERR;
  logic [7:0]  WR_CNT;

  ram_wr dut (
    .CLK_WR(CLK_WR), .RESET_N(RESET_N), .RAM_WEN(RAM_WEN),
    .RAM_AD_IN(RAM_AD_IN), .RAM_IN(RAM_IN), .ERR_CLR(ERR_CLR),
    .RAM_0(RAM_0), .RAM_1(RAM_1), .RAM_2(RAM_2), .RAM_3(RAM_3),
    .RAM_4(RAM_4), .RAM_5(RAM_5), .RAM_6(RAM_6), .RAM_7(RAM_7),
    .IO64_OUT(IO64_OUT), .IO64_STB(IO64_STB), .WR_ERR(WR_ERR), .WR_CNT(WR_CNT)
  );

  always #5 CLK_WR = ~CLK_WR;

  typedef struct packed {
    int               due;
    logic [7:0][15:0] ram;
    logic [15:0]      io;
    logic             stb;
    logic             err;
    logic [7:0]       cnt;
  } exp_t;

  exp_t        sq[$];
  logic [15:0] io_q[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge CLK_WR) cyc <= cyc + 1;

  // Reference model state
  logic [7:0][15:0] m_ram;
  logic [15:0]      m_io;
  logic             m_stb, m_err;
  logic [7:0]       m_cnt;
  logic             p_v;
  logic [7:0]       p_ad;
  logic [15:0]      p_d;

  logic [15:0] dut_ram [8];
  assign dut_ram[0] = RAM_0; assign dut_ram[1] = RAM_1;
  assign dut_ram[2] = RAM_2; assign dut_ram[3] = RAM_3;
  assign dut_ram[4] = RAM_4; assign dut_ram[5] = RAM_5;
  assign dut_ram[6] = RAM_6; assign dut_ram[7] = RAM_7;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_cnt(input logic [7:0] c);
`ifdef RAM_WR_COUNT_EN
    return c;
`else
    return 8'h00 & c;
`endif
  endfunction

  task automatic model_reset();
    m_ram = '0; m_io = 16'h0; m_stb = 1'b0; m_err = 1'b0; m_cnt = 8'h00;
    p_v = 1'b0; p_ad = 8'h00; p_d = 16'h0;
  endtask

  task automatic push_exp();
    exp_t e;
    e.due = cyc + 1;
    e.ram = m_ram;
    e.io  = m_io;
    e.stb = m_stb;
    e.err = m_err;
    e.cnt = exp_cnt(m_cnt);
    sq.push_back(e);
  endtask

  // Drive one cycle of stimulus and predict state after the following edge.
  task automatic step(input logic wen, input logic [7:0] ad, input logic [15:0] d, input logic clr);
    logic err_set;
    @(negedge CLK_WR);
    RAM_WEN = wen; RAM_AD_IN = ad; RAM_IN = d; ERR_CLR = clr;
    m_stb = 1'b0;
    err_set = 1'b0;
    if (p_v) begin
      if (p_ad < 8'h08) begin
        m_ram[p_ad[2:0]] = p_d;
        m_cnt = m_cnt + 8'h01;
      end else if (p_ad == 8'h40) begin
        m_io = p_d;
        m_stb = 1'b1;
        m_cnt = m_cnt + 8'h01;
        io_q.push_back(p_d);
      end else begin
        err_set = 1'b1;
      end
    end
    m_err = (m_err & ~clr) | err_set;
    p_v = wen; p_ad = ad; p_d = d;
    push_exp();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 8'h00, 16'h0000, 1'b0);
  endtask

  task automatic chk_all_zero(input string tag);
    for (int i = 0; i < 8; i++) chk($sformatf("%s_ram%0d", tag, i), {16'h0, dut_ram[i]}, 32'h0);
    chk({tag, "_io"},  {16'h0, IO64_OUT}, 32'h0);
    chk({tag, "_stb"}, {31'h0, IO64_STB}, 32'h0);
    chk({tag, "_err"}, {31'h0, WR_ERR}, 32'h0);
    chk({tag, "_cnt"}, {24'h0, WR_CNT}, 32'h0);
  endtask

  // Asynchronous reset pulse between two rising edges.
  task automatic mid_reset();
    @(negedge CLK_WR);
    RAM_WEN = 1'b0; ERR_CLR = 1'b0;
    #1 RESET_N = 1'b0;
    #1 chk_all_zero("async_rst");
    #1 RESET_N = 1'b1;
    model_reset();
    push_exp();
  endtask

  // Monitor: compare whenever the DUT presents a strobe or a scheduled state.
  always @(negedge CLK_WR) begin
    if (RESET_N === 1'b1) begin
      if (IO64_STB === 1'b1) begin
        if (io_q.size() == 0) begin
          chk("io64_unexpected_stb", 32'h1, 32'h0);
        end else begin
          chk("io64_stb_data", {16'h0, IO64_OUT}, {16'h0, io_q.pop_front()});
        end
      end
      while (sq.size() > 0 && sq[0].due <= cyc) begin
        exp_t e;
        e = sq.pop_front();
        for (int i = 0; i < 8; i++)
          chk($sformatf("ram%0d", i), {16'h0, dut_ram[i]}, {16'h0, e.ram[i]});
        chk("io64_out", {16'h0, IO64_OUT}, {16'h0, e.io});
        chk("io64_stb", {31'h0, IO64_STB}, {31'h0, e.stb});
        chk("wr_err",   {31'h0, WR_ERR},   {31'h0, e.err});
        chk("wr_cnt",   {24'h0, WR_CNT},   {24'h0, e.cnt});
      end
    end
  end

  initial begin
    RESET_N = 1'b0; RAM_WEN = 1'b0; RAM_AD_IN = 8'h00; RAM_IN = 16'h0; ERR_CLR = 1'b0;
    model_reset();
    repeat (2) @(posedge CLK_WR);
    #1 chk_all_zero("reset");
    @(negedge CLK_WR);
    RESET_N = 1'b1;

    // Single write to RAM_3
    step(1'b1, 8'h03, 16'h1234, 1'b0);
    idle(2);
    chk("d_ram3", {16'h0, RAM_3}, 32'h1234);
    chk("d_cnt1", {24'h0, WR_CNT}, {24'h0, exp_cnt(8'h01)});

    // Same-address back-to-back, later wins
    step(1'b1, 8'h00, 16'h0001, 1'b0);
    step(1'b1, 8'h00, 16'h0002, 1'b0);
    idle(2);
    chk("d_ram0", {16'h0, RAM_0}, 32'h0002);
    chk("d_cnt3", {24'h0, WR_CNT}, {24'h0, exp_cnt(8'h03)});

    // IO64 back-to-back
    step(1'b1, 8'h40, 16'hABCD, 1'b0);
    step(1'b1, 8'h40, 16'h5555, 1'b0);
    idle(3);
    chk("d_io64", {16'h0, IO64_OUT}, 32'h5555);

    // Unmapped write, clear, then clear colliding with a new error
    step(1'b1, 8'h10, 16'hDEAD, 1'b0);
    idle(2);
    chk("d_err_set", {31'h0, WR_ERR}, 32'h1);
    chk("d_cnt_unch", {24'h0, WR_CNT}, {24'h0, exp_cnt(8'h05)});
    step(1'b0, 8'h00, 16'h0, 1'b1);
    idle(1);
    chk("d_err_clr", {31'h0, WR_ERR}, 32'h0);
    step(1'b1, 8'h10, 16'hBEEF, 1'b0);
    step(1'b0, 8'h00, 16'h0, 1'b1);
    idle(1);
    chk("d_err_setwins", {31'h0, WR_ERR}, 32'h1);
    step(1'b0, 8'h00, 16'h0, 1'b1);
    idle(1);

    // Reset while a write sits in S1
    step(1'b1, 8'h07, 16'hBEEF, 1'b0);
    mid_reset();
    idle(2);
    chk("d_ram7_discard", {16'h0, RAM_7}, 32'h0);
    step(1'b1, 8'h07, 16'hC0DE, 1'b0);
    idle(2);
    chk("d_ram7_after", {16'h0, RAM_7}, 32'hC0DE);

    // Counter wrap
    mid_reset();
    for (int i = 0; i < 255; i++) step(1'b1, 8'(i % 8), 16'(i), 1'b0);
    idle(2);
    chk("d_cnt_ff", {24'h0, WR_CNT}, {24'h0, exp_cnt(8'hFF)});
    step(1'b1, 8'h40, 16'h0F0F, 1'b0);
    idle(2);
    chk("d_cnt_wrap", {24'h0, WR_CNT}, 32'h0);

    idle(2);
    @(negedge CLK_WR);
    @(negedge CLK_WR);
    chk("sq_drained", sq.size(), 32'h0);
    chk("io_q_drained", io_q.size(), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1);
  end

endmodule

// File: doc/ram_wr.md
RAM_WR -- requirements
Module: ram_wr

Interface
REQ-001 CLK_WR  input  1  single system clock; all state updates on rising edge.
REQ-002 RESET_N  input  1  reset, asynchronous assert, active-low.
REQ-003 RAM_WEN  input  1  write request, sampled each rising edge.
REQ-004 RAM_AD_IN  input  8  write address, valid when RAM_WEN=1.
REQ-005 RAM_IN  input  16  write data, valid when RAM_WEN=1.
REQ-006 ERR_CLR  input  1  clears WR_ERR.
REQ-007 RAM_0 .. RAM_7  output  16 each  registered word storage; these drive the RAM read decoder inputs of the same name.
REQ-008 IO64_OUT  output  16  registered output port mapped at address 8'h40.
REQ-009 IO64_STB  output  1  one-cycle pulse marking an IO64_OUT update.
REQ-010 WR_ERR  output  1  sticky flag for a write to an unmapped address.
REQ-011 WR_CNT  output  8  count of committed writes.

Function
REQ-012 Two-stage pipeline: stage S1 registers RAM_WEN, RAM_AD_IN and RAM_IN; stage S2 commits from S1 on the next edge.
- Write sampled at edge N is visible on RAM_x / IO64_OUT after edge N+1 (latency 2).
REQ-013 A request is accepted on every cycle with RAM_WEN=1; there is no busy or stall condition, and back-to-back writes commit in issue order.
REQ-014 Address map at commit:
- 8'h00..8'h07 -> RAM_0..RAM_7
- 8'h40 -> IO64_OUT
- any other address is unmapped.
REQ-015 Consecutive writes to the same address both commit in order; the later data wins.
REQ-016 An unmapped write modifies no storage, does not increment WR_CNT, and sets WR_ERR on the commit edge.
REQ-017 IO64_STB is 1 for exactly the cycle after an IO64_OUT commit, and 0 otherwise.
- Back-to-back IO64 writes hold IO64_STB high for consecutive cycles, one cycle per write.
REQ-018 WR_ERR stays set until an edge with ERR_CLR=1.
- If ERR_CLR and a new unmapped commit occur on the same edge, WR_ERR ends set (set wins).
REQ-019 WR_CNT increments by 1 per mapped commit, modulo 256; 8'hFF wraps to 8'h00.
REQ-020 All outputs are driven directly from registers, with no combinational path from any input to any output.

Reset
REQ-021 With RESET_N=0, the block asynchronously forces:
- RAM_0..RAM_7 = 16'h0000, IO64_OUT = 16'h0000
- IO64_STB = 0, WR_ERR = 0, WR_CNT = 8'h00
- S1 valid = 0.
REQ-022 Reset asserted while a write is held in S1 discards that write; it never commits.
REQ-023 After RESET_N deasserts, the first RAM_WEN=1 edge is accepted normally.

Configuration
REQ-024 Macro RAM_WR_COUNT_EN:
- Defined: WR_CNT behaves per REQ-019.
- Undefined: the counter logic is omitted and WR_CNT is constant 8'h00.
- All other behaviour is identical in both cases.

Verification
REQ-025 Reset; write 16'h1234 to 8'h03 at edge N -> RAM_3=16'h1234 after edge N+1, other words 0, WR_CNT=1.
REQ-026 Writes to 8'h40 with 16'hABCD then 16'h5555 on consecutive cycles -> IO64_OUT=16'hABCD then 16'h5555; IO64_STB high for two cycles.
REQ-027 Write to 8'h10 -> no storage change, WR_CNT unchanged, WR_ERR=1; ERR_CLR pulse -> WR_ERR=0; ERR_CLR on the same edge as a second 8'h10 commit -> WR_ERR=1.
REQ-028 256 mapped writes from reset -> WR_CNT=8'h00; 255 mapped writes -> WR_CNT=8'hFF; without RAM_WR_COUNT_EN, WR_CNT=8'h00 throughout.
REQ-029 Write 16'hBEEF to 8'h07, then assert RESET_N=0 between edge N and N+1 -> RAM_7=16'h0000 after release; a following write commits normally.
REQ-030 Writes 16'h0001 then 16'h0002 to 8'h00 on consecutive cycles -> RAM_0=16'h0001 then 16'h0002; WR_CNT advances by 2.
